// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared constants, scan-out state and address-region decode for hack_data_memory
package hack_mem_pkg;
    localparam logic [14:0] SCREEN_BASE  = 15'h4000;
    localparam logic [14:0] KBD_ADDR     = 15'h6000;
    localparam int          RAM_WORDS    = 16384;
    localparam int          SCREEN_WORDS = 8192;

    typedef enum logic {FETCH, SHIFT} scan_state_t;

    typedef enum logic [1:0] {REGION_RAM, REGION_SCREEN, REGION_KBD, REGION_UNMAPPED} region_t;

    function automatic region_t decode_region(input logic [14:0] addr);
        return addr < SCREEN_BASE ? REGION_RAM :
               addr < KBD_ADDR    ? REGION_SCREEN :
               addr == KBD_ADDR   ? REGION_KBD : REGION_UNMAPPED;
    endfunction
endpackage

// File: rtl/hack_scanout.sv
// hack_scanout: streams the screen buffer as a valid/ready pixel stream, 16 pixels per fetched word
module hack_scanout
    import hack_mem_pkg::*;
#(
    parameter int SCREEN_ROWS   = 256,
    parameter int WORDS_PER_ROW = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [12:0] scr_addr,
    input  logic [15:0] scr_data,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic        pix_data,
    output logic        pix_sol,
    output logic        pix_sof
);
    localparam int RW = $clog2(SCREEN_ROWS);
    localparam int CW = $clog2(WORDS_PER_ROW);

    scan_state_t state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   word_q, word_d;
    logic          pix_valid_q, pix_valid_d;
    logic          pix_data_q, pix_data_d;
    logic          pix_sol_q, pix_sol_d;
    logic          pix_sof_q, pix_sof_d;
    logic          last_col, last_row;

    assign scr_addr  = 13'(int'(row_q) * WORDS_PER_ROW + int'(col_q));
    assign last_col  = col_q == CW'(WORDS_PER_ROW - 1);
    assign last_row  = row_q == RW'(SCREEN_ROWS - 1);
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_sol   = pix_sol_q;
    assign pix_sof   = pix_sof_q;

    // next fetch/shift position; outputs are derived from the next position so they register alongside it
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        bit_idx_d = bit_idx_q;
        col_d     = col_q;
        row_d     = row_q;
        if (state_q == FETCH) begin
            word_d    = scr_data;
            bit_idx_d = 4'd0;
            state_d   = SHIFT;
        end else if (pix_ready) begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q == 4'd15) begin
                state_d = FETCH;
                col_d   = last_col ? '0 : col_q + 1'b1;
                row_d   = !last_col ? row_q : last_row ? '0 : row_q + 1'b1;
            end
        end
        pix_valid_d = state_d == SHIFT;
        pix_data_d  = pix_valid_d & word_d[bit_idx_d];
        pix_sol_d   = pix_valid_d && bit_idx_d == 4'd0 && col_d == '0;
        pix_sof_d   = pix_sol_d && row_d == '0;
    end

    // scan-out state and registered pixel outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            word_q      <= '0;
            bit_idx_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= 1'b0;
            pix_sol_q   <= 1'b0;
            pix_sof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            bit_idx_q   <= bit_idx_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_sol_q   <= pix_sol_d;
            pix_sof_q   <= pix_sof_d;
        end
    end
endmodule

// File: rtl/hack_data_memory.sv
// hack_data_memory: Hack CPU data memory (RAM, screen, KBD) with keyboard capture; HACK_SCANOUT_EN builds the pixel scan-out
module hack_data_memory
    import hack_mem_pkg::*;
#(
    parameter int SCREEN_ROWS   = 256,
    parameter int WORDS_PER_ROW = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic        writeM,
    input  logic [15:0] outM,
    output logic [15:0] inM,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    output logic        kbd_ready,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_data,
    output logic        pix_sol,
    output logic        pix_sof
);
    logic [15:0] ram [RAM_WORDS];
    logic [15:0] screen [SCREEN_WORDS];
    logic [15:0] kbd_q, kbd_d;
    region_t     region;

    assign region    = decode_region(addressM);
    assign kbd_ready = ~reset;

    // combinational CPU read per memory map; unmapped reads as zero
    always_comb begin
        inM = region == REGION_RAM    ? ram[addressM[13:0]] :
              region == REGION_SCREEN ? screen[addressM[12:0]] :
              region == REGION_KBD    ? kbd_q : 16'h0000;
    end

    // CPU writes land in RAM or screen only; KBD and unmapped writes are dropped
    always_ff @(posedge clk) begin
        if (writeM && region == REGION_RAM) ram[addressM[13:0]] <= outM;
        if (writeM && region == REGION_SCREEN) screen[addressM[12:0]] <= outM;
    end

    // latest accepted keyboard code, zero meaning no key held
    always_comb begin
        kbd_d = (kbd_valid && kbd_ready) ? kbd_code : kbd_q;
    end

    // keyboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) kbd_q <= '0;
        else kbd_q <= kbd_d;
    end

`ifdef HACK_SCANOUT_EN
    logic [12:0] scan_addr;

    hack_scanout #(
        .SCREEN_ROWS  (SCREEN_ROWS),
        .WORDS_PER_ROW(WORDS_PER_ROW)
    ) u_scanout (
        .clk      (clk),
        .reset    (reset),
        .scr_addr (scan_addr),
        .scr_data (screen[scan_addr]),
        .pix_ready(pix_ready),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .pix_sol  (pix_sol),
        .pix_sof  (pix_sof)
    );
`else
    logic [31:0] unused_cfg;

    assign unused_cfg = {31'(SCREEN_ROWS * WORDS_PER_ROW), pix_ready};
    assign pix_valid  = 1'b0;
    assign pix_data   = 1'b0;
    assign pix_sol    = 1'b0;
    assign pix_sof    = 1'b0;
`endif
endmodule

// File: doc/hack_data_memory.md
# hack_data_memory

Data-memory responder for the Hack CPU: it serves the CPU's `addressM`/`writeM`/`outM` request and returns `inM` per the Hack memory map. The map is 16K-word RAM, an 8K-word screen buffer and the keyboard register. The block also captures keyboard codes from a keyboard front end. A scan-out engine streams the screen buffer to the display as a valid/ready pixel stream. It sits between `cpu` and the board I/O.

## Interface
Parameters:
- `SCREEN_ROWS`, 256, display rows.
- `WORDS_PER_ROW`, 32, 16-bit words per row (512 pixels).

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  reset, asynchronous and active-high.
- `addressM`  in  15  CPU data address.
- `writeM`  in  1  CPU write strobe.
- `outM`  in  16  CPU write data.
- `inM`  out  16  read data to CPU, combinational from `addressM`.
- `kbd_valid`  in  1  keyboard code offered.
- `kbd_code`  in  16  keyboard code; 0 means key released.
- `kbd_ready`  out  1  keyboard code accepted when high with `kbd_valid`.
- `pix_valid`  out  1  pixel on `pix_data` is valid.
- `pix_ready`  in  1  display sink accepts the pixel.
- `pix_data`  out  1  pixel value; 1 = black.
- `pix_sol`  out  1  pixel is first of a row.
- `pix_sof`  out  1  pixel is first of a frame.

## Operation
- Memory map by `addressM`:
  - 0x0000–0x3FFF: RAM.
  - 0x4000–0x5FFF: screen buffer.
  - 0x6000: keyboard register (KBD).
  - 0x6001–0x7FFF: unmapped.
- Reads are combinational:
  - `inM` = RAM or screen word, or KBD.
  - Unmapped addresses read 0x0000.
- Writes occur at posedge when `writeM`=1:
  - RAM and screen accept writes.
  - Writes to KBD or to unmapped addresses are ignored.
- Keyboard capture:
  - `kbd_ready` is constantly 1 outside reset.
  - On `kbd_valid`, KBD <= `kbd_code`.
  - KBD holds its value until the next accepted code; code 0 clears it.
- Scan-out FSM, states FETCH and SHIFT:
  - FETCH: loads shift word = screen[row*WORDS_PER_ROW + col] and clears `bit`; next state is SHIFT. `pix_valid`=0 in FETCH.
  - SHIFT: `pix_valid`=1, `pix_data`=word[`bit`] (bit 0 is the leftmost pixel). The pixel advances only on `pix_valid & pix_ready`.
  - After bit 15 is accepted, `col` increments and the FSM returns to FETCH.
  - `col` wraps at WORDS_PER_ROW-1 and increments `row`; `row` wraps at SCREEN_ROWS-1 to 0, restarting the frame.
  - `pix_sol` = (`bit`==0 && `col`==0); `pix_sof` = `pix_sol` && `row`==0.

## Timing
- Reset values:
  - `pix_valid`=0, `pix_data`=0, `pix_sol`=0, `pix_sof`=0, `kbd_ready`=0.
  - KBD=0; `row`=`col`=`bit`=0; FSM in FETCH.
  - RAM and screen contents are not reset.
- Reset is asynchronous, so asserting it mid-stream immediately drops `pix_valid` and restarts at pixel (0,0).
- After reset deasserts, the first `pix_valid` is seen in the 2nd cycle: one cycle in FETCH, then SHIFT.
- Read-after-write: a word written at edge N is visible on `inM` and to scan-out from edge N onward.
- Simultaneous CPU write and FETCH of the same screen word: FETCH captures the pre-write value.
- Throughput: 16 pixels per 17 cycles with `pix_ready` held high.
- Stall: while `pix_ready`=0, `pix_data`, `pix_sol` and `pix_sof` hold stable.
- A KBD update is visible on `inM` in the cycle after acceptance.

## Configuration
- `HACK_SCANOUT_EN` defined:
  - The scan-out engine and the screen second read port are built.
- Undefined:
  - No scan-out logic is built.
  - `pix_valid`, `pix_data`, `pix_sol` and `pix_sof` are tied to 0; `pix_ready` is ignored.
  - The screen region remains CPU-readable and writable.

## Structure
- Package `hack_mem_pkg` holds:
  - Constants: `SCREEN_BASE`=15'h4000, `KBD_ADDR`=15'h6000, `RAM_WORDS`=16384, `SCREEN_WORDS`=8192.
  - The scan-out state enum.
  - The address-region decode typedef (RAM, SCREEN, KBD, UNMAPPED).
- Sub-module `hack_scanout` contains the FSM, counters and shift word. It exposes a screen word-address output and a word-data input and lives under the `HACK_SCANOUT_EN` guard.
- RAM and screen arrays and the KBD register live in the top module.

## Test plan
- RAM round trip: write 0x1234 to 0x0005, then read 0x0005 -> `inM`=0x1234 the next cycle. Read 0x6001 -> 0x0000.
- Keyboard: `kbd_valid` with code 0x0041 -> read 0x6000 = 0x0041. Code 0 -> 0x0000. CPU write 0xFFFF to 0x6000 -> KBD unchanged.
- Scan-out pattern: screen[0]=0x0001, `pix_ready`=1 -> first pixel `pix_data`=1 with `pix_sof`=`pix_sol`=1, next 15 pixels =0, one bubble, then word 1.
- Backpressure: deassert `pix_ready` for 5 cycles mid-word -> outputs stable, no pixel lost, and the 16-pixel sequence completes intact.
- Wrap: run 256×512 accepted pixels -> `pix_sof` reasserts exactly at pixel 131072. Assert `reset` mid-row -> `pix_valid`=0 immediately, and the stream restarts with `pix_sof`.
- Config: build without `HACK_SCANOUT_EN` -> `pix_valid` stays 0, and a screen write/read at 0x4000 still round-trips.
